// File: rtl/sram_like_ram_slave.sv
// ---------------------------------------------------------------------------
// sram_like_ram_slave
//
// Responder for the SRAM-like bus. A word-addressed RAM sits behind a small
// in-order response queue. Each queued response waits at least RESP_LAT
// cycles after acceptance before it is returned.
//
// Ports
//   clk      clock; all state updates on posedge
//   reset    synchronous, active-high; empties the queue, RAM is untouched
//   req      request valid from the initiator
//   wr       1 = write, 0 = read
//   size     transfer size (informational; byte lanes come from wstrb)
//   wstrb    byte-lane write enables for writes
//   addr     byte address; word index is addr[ADDR_W+1:2]
//   wdata    write data
//   rdata    response data; zero whenever data_ok is low
//   addr_ok  request accepted this cycle
//   data_ok  response for the oldest outstanding request this cycle
//   hold     throttle input; forces addr_ok low while high
//
// Parameters
//   ADDR_W    word-index bits; the RAM holds 2**ADDR_W 32-bit words
//   QDEPTH    maximum accepted-but-unanswered requests (power of 2, >= 2)
//   RESP_LAT  minimum cycles from addr_ok to data_ok (>= 1)
// ---------------------------------------------------------------------------
module sram_like_ram_slave #(
  parameter int ADDR_W   = 10,
  parameter int QDEPTH   = 4,
  parameter int RESP_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok,
  input  logic        hold
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int AGE_W = $clog2(RESP_LAT + 1);

  logic [31:0]       mem    [2**ADDR_W];
  logic [31:0]       q_data [QDEPTH];
  logic [AGE_W-1:0]  q_age  [QDEPTH];
  logic [QDEPTH-1:0] q_vld;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] idx;
  logic              push;
  logic              pop;

  // Only the word-index bits of the address and the strobes steer the RAM.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  // Age counters stop at RESP_LAT so they never wrap while the head waits.
  function automatic logic [AGE_W-1:0] sat_age(input logic [AGE_W-1:0] a);
    if (a >= AGE_W'(RESP_LAT))
      return AGE_W'(RESP_LAT);
    else
      return a + 1'b1;
  endfunction

  assign idx = addr[ADDR_W+1:2];

  // Fullness is judged on the registered count: a pop in the same cycle
  // does not make room for a new request until the next cycle.
  assign addr_ok = req & ~hold & (count < CNT_W'(QDEPTH)) & ~reset;
  assign push    = addr_ok;

  assign data_ok = q_vld[head] & (q_age[head] >= AGE_W'(RESP_LAT)) & ~reset;
  assign pop     = data_ok;
  assign rdata   = data_ok ? q_data[head] : 32'd0;

  // RAM write port: only the strobed byte lanes change.
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b])
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Queue payload: a read snapshots the RAM word as it stands in the accept
  // cycle; a write answers with zero.
  always_ff @(posedge clk) begin
    if (push)
      q_data[tail] <= wr ? 32'd0 : mem[idx];
  end

  // Queue control: pointers, occupancy, per-entry valid and age.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_vld <= '0;
      for (int i = 0; i < QDEPTH; i++)
        q_age[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_vld[i])
          q_age[i] <= sat_age(q_age[i]);
      end
      if (pop) begin
        q_vld[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push) begin
        q_vld[tail] <= 1'b1;
        q_age[tail] <= AGE_W'(1);
        tail        <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_ram_slave.sv
// ---------------------------------------------------------------------------
// Bench for sram_like_ram_slave. Two instances are driven: dut0 with
// RESP_LAT=2 and dut1 with RESP_LAT=4, both QDEPTH=4, ADDR_W=10.
// A per-instance scoreboard records the expected data and response cycle of
// every accepted request; a negedge monitor checks addr_ok, data_ok, rdata
// and response timing against it every cycle.
// ---------------------------------------------------------------------------
module tb_sram_like_ram_slave;

  logic        clk = 1'b0;
  logic        reset   [2];
  logic        req     [2];
  logic        wr      [2];
  logic [1:0]  size    [2];
  logic [3:0]  wstrb   [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [31:0] rdata   [2];
  logic        addr_ok [2];
  logic        data_ok [2];
  logic        hold    [2];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  // Reference memory and scoreboard FIFOs, one set per instance.
  logic [31:0] mdl     [2][1024];
  logic [31:0] sb_data [2][16];
  int          sb_cyc  [2][16];
  int          sb_head [2];
  int          sb_cnt  [2];
  int          last_exp[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_like_ram_slave #(.ADDR_W(10), .QDEPTH(4), .RESP_LAT(2)) dut0 (
    .clk(clk), .reset(reset[0]), .req(req[0]), .wr(wr[0]), .size(size[0]),
    .wstrb(wstrb[0]), .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
    .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .hold(hold[0])
  );

  sram_like_ram_slave #(.ADDR_W(10), .QDEPTH(4), .RESP_LAT(4)) dut1 (
    .clk(clk), .reset(reset[1]), .req(req[1]), .wr(wr[1]), .size(size[1]),
    .wstrb(wstrb[1]), .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
    .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .hold(hold[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic       exp_aok;
    logic [9:0] idx;
    int         lat;
    int         t;
    int         tl;
    for (int d = 0; d < 2; d++) begin
      lat     = (d == 0) ? 2 : 4;
      exp_aok = req[d] & ~hold[d] & (sb_cnt[d] < 4) & ~reset[d];
      check($sformatf("addr_ok%0d", d), {31'd0, addr_ok[d]}, {31'd0, exp_aok});
      if (reset[d]) begin
        check($sformatf("rst_data_ok%0d", d), {31'd0, data_ok[d]}, 32'd0);
        check($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
        sb_head[d]  = 0;
        sb_cnt[d]   = 0;
        last_exp[d] = 0;
      end else begin
        if (data_ok[d]) begin
          if (sb_cnt[d] == 0) begin
            check($sformatf("unexpected_data_ok%0d", d), {31'd0, data_ok[d]}, 32'd0);
          end else begin
            check($sformatf("rdata%0d", d), rdata[d], sb_data[d][sb_head[d]]);
            check($sformatf("resp_cycle%0d", d), cyc, sb_cyc[d][sb_head[d]]);
            sb_head[d] = (sb_head[d] + 1) % 16;
            sb_cnt[d]--;
          end
        end else begin
          check($sformatf("idle_rdata%0d", d), rdata[d], 32'd0);
          if (sb_cnt[d] != 0 && cyc >= sb_cyc[d][sb_head[d]])
            check($sformatf("late_data_ok%0d", d), {31'd0, data_ok[d]}, 32'd1);
        end
        if (addr_ok[d]) begin
          idx = addr[d][11:2];
          t   = cyc + lat;
          if (t <= last_exp[d]) t = last_exp[d] + 1;
          last_exp[d] = t;
          tl = (sb_head[d] + sb_cnt[d]) % 16;
          sb_cyc[d][tl] = t;
          if (wr[d]) begin
            for (int b = 0; b < 4; b++)
              if (wstrb[d][b]) mdl[d][idx][8*b +: 8] = wdata[d][8*b +: 8];
            sb_data[d][tl] = 32'd0;
          end else begin
            sb_data[d][tl] = mdl[d][idx];
          end
          sb_cnt[d]++;
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic slot();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] s);
    req[d]   = r;
    wr[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    wstrb[d] = s;
    size[d]  = 2'd2;
  endtask

  // Present one request and hold it until accepted; returns in the next
  // drive slot with req low so a following send() issues back-to-back.
  task automatic send(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s);
    logic ok;
    ok = 1'b0;
    drive(d, 1'b1, w, a, wd, s);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (addr_ok[d]) ok = 1'b1;
      else slot();
    end
    check("accepted", {31'd0, ok}, 32'd1);
    slot();
    req[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 60 && sb_cnt[d] != 0; i++) slot();
    check("drained", sb_cnt[d], 32'd0);
    slot();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc[8];
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1;
      hold[d]  = 1'b0;
      drive(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      sb_head[d] = 0; sb_cnt[d] = 0; last_exp[d] = 0;
    end
    // Requests presented during reset must not be accepted.
    req[0] = 1'b1;
    repeat (3) slot();
    @(negedge clk);
    check("rst_addr_ok", {31'd0, addr_ok[0]}, 32'd0);
    check("rst_data_ok", {31'd0, data_ok[0]}, 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    slot();
    req[0]   = 1'b0;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    slot();

    // Preload and single read with latency 2.
    send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    send(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF);
    drain(0);
    send(0, 1'b0, 32'h10, 32'd0, 4'd0);
    drain(0);

    // Partial write followed by a back-to-back read of the same word.
    send(0, 1'b1, 32'h20, 32'h11223344, 4'b0101);
    send(0, 1'b0, 32'h20, 32'd0, 4'd0);
    drain(0);
    check("merged_word_model", mdl[0][8], 32'hAA22CC44);

    // Throttle: queued response emerges while hold blocks new accepts.
    send(0, 1'b0, 32'h10, 32'd0, 4'd0);
    hold[0] = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h20, 32'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_blocks", {31'd0, addr_ok[0]}, 32'd0);
      slot();
    end
    hold[0] = 1'b0;
    @(negedge clk);
    check("accept_after_hold", {31'd0, addr_ok[0]}, 32'd1);
    slot();
    req[0] = 1'b0;
    drain(0);

    // Address aliasing: both addresses map to word index 1.
    send(0, 1'b1, 32'h1000_0004, 32'h5A5A1234, 4'hF);
    send(0, 1'b0, 32'h0000_1004, 32'd0, 4'd0);
    drain(0);

    // Fill the queue on the RESP_LAT=4 instance.
    for (int i = 0; i < 8; i++) send(1, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
    send(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    drain(1);
    n = 0;
    drive(1, 1'b1, 1'b0, 32'h0, 32'd0, 4'd0);
    for (int i = 0; i < 100 && n < 8; i++) begin
      @(negedge clk);
      if (addr_ok[1]) begin
        acc[n] = cyc;
        n++;
      end
      slot();
      addr[1] = 32'(n * 4);
    end
    req[1] = 1'b0;
    check("fill_accepts", n, 32'd8);
    check("burst_span", acc[3] - acc[0], 32'd3);
    check("refill_gap", acc[4] - acc[0], 32'd5);
    drain(1);

    // Reset with three outstanding reads: all are discarded.
    send(1, 1'b0, 32'h0, 32'd0, 4'd0);
    send(1, 1'b0, 32'h4, 32'd0, 4'd0);
    send(1, 1'b0, 32'h8, 32'd0, 4'd0);
    reset[1] = 1'b1;
    repeat (2) slot();
    reset[1] = 1'b0;
    repeat (6) slot();
    send(1, 1'b0, 32'h40, 32'd0, 4'd0);
    send(1, 1'b0, 32'h0, 32'd0, 4'd0);
    drain(1);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
